// File: rtl/unidade_controle.sv
// Memory-game control unit: Moore FSM that sequences the datapath through
// rounds of growing length and reports win / error / timeout.
module unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       igual,
    input  logic       fim_sequencia,
    input  logic       ultima_sequencia,
    input  logic       jogada_feita,
    input  logic       fim_timer,
    input  logic       fimE,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       zera_timer,
    output logic       conta_timer,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL          = 4'h0,
        PREPARACAO       = 4'h1,
        INICIO_RODADA    = 4'h2,
        ESPERA_JOGADA    = 4'h3,
        REGISTRA         = 4'h4,
        COMPARACAO       = 4'h5,
        PROXIMO_ENDERECO = 4'h6,
        PROXIMA_RODADA   = 4'h7,
        FIM_ACERTOU      = 4'h8,
        FIM_ERROU        = 4'h9,
        FIM_TIMEOUT      = 4'hA
    } estado_t;

    estado_t estado_q, estado_d;

    // Address counter rco is debug only; round end comes from fim_sequencia.
    logic unused_fime;
    assign unused_fime = fimE;

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) estado_q <= INICIAL;
        else        estado_q <= estado_d;
    end

    // Next-state logic; illegal codes fall back to inicial.
    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:          estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:       estado_d = INICIO_RODADA;
            INICIO_RODADA:    estado_d = ESPERA_JOGADA;
            // A play arriving with the timeout in the same cycle wins.
            ESPERA_JOGADA:    estado_d = jogada_feita ? REGISTRA :
                                         fim_timer    ? FIM_TIMEOUT : ESPERA_JOGADA;
            REGISTRA:         estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual)                                  estado_d = FIM_ERROU;
                else if (fim_sequencia && ultima_sequencia)  estado_d = FIM_ACERTOU;
                else if (fim_sequencia)                      estado_d = PROXIMA_RODADA;
                else                                         estado_d = PROXIMO_ENDERECO;
            end
            PROXIMO_ENDERECO: estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA:   estado_d = INICIO_RODADA;
            FIM_ACERTOU,
            FIM_ERROU,
            FIM_TIMEOUT:      estado_d = iniciar ? PREPARACAO : estado_q;
            default:          estado_d = INICIAL;
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        zeraE       = 1'b0;
        contaE      = 1'b0;
        zeraL       = 1'b0;
        contaL      = 1'b0;
        zeraR       = 1'b0;
        registraR   = 1'b0;
        zera_timer  = 1'b0;
        conta_timer = 1'b0;
        pronto      = 1'b0;
        acertou     = 1'b0;
        errou       = 1'b0;
        timeout     = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zeraE      = 1'b1;
                zeraL      = 1'b1;
                zeraR      = 1'b1;
                zera_timer = 1'b1;
            end
            INICIO_RODADA: begin
                zeraE      = 1'b1;
                zera_timer = 1'b1;
            end
            ESPERA_JOGADA:    conta_timer = 1'b1;
            REGISTRA:         registraR   = 1'b1;
            // Fresh timeout window for every play of the round.
            PROXIMO_ENDERECO: begin
                contaE     = 1'b1;
                zera_timer = 1'b1;
            end
            PROXIMA_RODADA:   contaL = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: directed scenarios plus random stimulus, all
// compared every cycle against a behavioural model of the game rules.
module tb_unidade_controle;

    logic       clock = 1'b0;
    logic       reset, iniciar, igual, fim_sequencia, ultima_sequencia;
    logic       jogada_feita, fim_timer, fimE;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic       zera_timer, conta_timer, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int passed = 0;

    logic [3:0]  exp_st = 4'h0;
    logic [11:0] out_tab [16];

    unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .igual(igual),
        .fim_sequencia(fim_sequencia), .ultima_sequencia(ultima_sequencia),
        .jogada_feita(jogada_feita), .fim_timer(fim_timer), .fimE(fimE),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .zera_timer(zera_timer),
        .conta_timer(conta_timer), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Output bundle order:
    // zeraE contaE zeraL contaL zeraR registraR zera_timer conta_timer pronto acertou errou timeout
    function automatic logic [11:0] outs();
        return {zeraE, contaE, zeraL, contaL, zeraR, registraR,
                zera_timer, conta_timer, pronto, acertou, errou, timeout};
    endfunction

    // Game rules: which state follows, given the current one and the inputs.
    function automatic logic [3:0] model_next(input logic [3:0] s);
        if (!reset) return 4'h0;
        if (s == 4'h0) return iniciar ? 4'h1 : 4'h0;
        if (s == 4'h1) return 4'h2;
        if (s == 4'h2) return 4'h3;
        if (s == 4'h3) return jogada_feita ? 4'h4 : (fim_timer ? 4'hA : 4'h3);
        if (s == 4'h4) return 4'h5;
        if (s == 4'h5) begin
            if (!igual) return 4'h9;
            if (fim_sequencia) return ultima_sequencia ? 4'h8 : 4'h7;
            return 4'h6;
        end
        if (s == 4'h6) return 4'h3;
        if (s == 4'h7) return 4'h2;
        if (s >= 4'h8 && s <= 4'hA) return iniciar ? 4'h1 : s;
        return 4'h0;
    endfunction

    // Advance one edge, then compare against the model and optionally a literal code.
    task automatic tick(input string name, input bit chk, input logic [3:0] want);
        exp_st = model_next(exp_st);
        @(posedge clock);
        #1;
        checks++;
        if (db_estado !== exp_st || outs() !== out_tab[exp_st])
            $display("FAIL %s model: state %h outs %b, expected state %h outs %b",
                     name, db_estado, outs(), exp_st, out_tab[exp_st]);
        else passed++;
        if (chk) begin
            checks++;
            if (db_estado !== want)
                $display("FAIL %s state: got %h expected %h", name, db_estado, want);
            else passed++;
        end
    endtask

    task automatic idle_inputs();
        iniciar = 0; igual = 0; fim_sequencia = 0; ultima_sequencia = 0;
        jogada_feita = 0; fim_timer = 0; fimE = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        tick("reset0", 1, 4'h0);
        tick("reset1", 1, 4'h0);
        checks++;
        if (outs() !== 12'h000) $display("FAIL reset_outs: got %b expected 0", outs());
        else passed++;
        reset = 1;
        tick("reset_rel", 1, 4'h0);
    endtask

    task automatic test_start();
        iniciar = 1;
        tick("start1", 1, 4'h1);
        checks++;
        if ({zeraE, zeraL, zeraR, zera_timer} !== 4'b1111)
            $display("FAIL start_clears: got %b expected 1111", {zeraE, zeraL, zeraR, zera_timer});
        else passed++;
        iniciar = 0;
        tick("start2", 1, 4'h2);
        tick("start3", 1, 4'h3);
    endtask

    task automatic test_round1();
        int contal_cnt = 0;
        igual = 1; fim_sequencia = 1; ultima_sequencia = 0; jogada_feita = 1;
        tick("r1_reg", 1, 4'h4);
        jogada_feita = 0;
        tick("r1_cmp", 1, 4'h5);
        tick("r1_prox", 1, 4'h7); contal_cnt += int'(contaL);
        tick("r1_ini", 1, 4'h2);  contal_cnt += int'(contaL);
        tick("r1_esp", 1, 4'h3);  contal_cnt += int'(contaL);
        checks++;
        if (contal_cnt != 1) $display("FAIL r1_contaL_pulse: got %0d cycles expected 1", contal_cnt);
        else passed++;
    endtask

    task automatic test_mid_error();
        fim_sequencia = 0; igual = 1; jogada_feita = 1;
        tick("mid_reg", 1, 4'h4);
        jogada_feita = 0;
        tick("mid_cmp", 1, 4'h5);
        tick("mid_prox", 1, 4'h6);
        checks++;
        if ({contaE, zera_timer} !== 2'b11)
            $display("FAIL mid_contaE: got %b expected 11", {contaE, zera_timer});
        else passed++;
        tick("mid_esp", 1, 4'h3);
        igual = 0; jogada_feita = 1;
        tick("err_reg", 1, 4'h4);
        jogada_feita = 0;
        tick("err_cmp", 1, 4'h5);
        tick("err_end", 1, 4'h9);
        checks++;
        if ({pronto, errou, acertou, timeout} !== 4'b1100)
            $display("FAIL err_flags: got %b expected 1100", {pronto, errou, acertou, timeout});
        else passed++;
        tick("err_hold1", 1, 4'h9);
        tick("err_hold2", 1, 4'h9);
        iniciar = 1;
        tick("err_restart", 1, 4'h1);
        iniciar = 0;
        tick("err_r2", 1, 4'h2);
        tick("err_r3", 1, 4'h3);
    endtask

    task automatic test_timeout_tie();
        fim_timer = 1;
        tick("to_end", 1, 4'hA);
        fim_timer = 0;
        checks++;
        if ({pronto, timeout, errou, acertou} !== 4'b1100)
            $display("FAIL to_flags: got %b expected 1100", {pronto, timeout, errou, acertou});
        else passed++;
        iniciar = 1;
        tick("to_restart", 1, 4'h1);
        iniciar = 0;
        tick("to_r2", 1, 4'h2);
        tick("to_r3", 1, 4'h3);
        jogada_feita = 1; fim_timer = 1;
        tick("tie", 1, 4'h4);
        jogada_feita = 0; fim_timer = 0; igual = 1; fim_sequencia = 0;
        tick("tie_cmp", 1, 4'h5);
        tick("tie_prox", 1, 4'h6);
        tick("tie_esp", 1, 4'h3);
    endtask

    task automatic test_win();
        igual = 1; fim_sequencia = 1; ultima_sequencia = 1; jogada_feita = 1;
        tick("win_reg", 1, 4'h4);
        jogada_feita = 0;
        tick("win_cmp", 1, 4'h5);
        tick("win_end", 1, 4'h8);
        checks++;
        if ({pronto, acertou, errou, timeout} !== 4'b1100)
            $display("FAIL win_flags: got %b expected 1100", {pronto, acertou, errou, timeout});
        else passed++;
        // iniciar held high: restart once, then ignored mid-game.
        iniciar = 1;
        tick("win_restart", 1, 4'h1);
        tick("win_hold2", 1, 4'h2);
        tick("win_hold3", 1, 4'h3);
        tick("win_hold4", 1, 4'h3);
        iniciar = 0;
    endtask

    task automatic test_reset_mid();
        reset = 0;
        tick("rmid0", 1, 4'h0);
        tick("rmid1", 1, 4'h0);
        reset = 1;
        tick("rmid_rel1", 1, 4'h0);
        tick("rmid_rel2", 1, 4'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset            = ($urandom_range(63) != 0);
            iniciar          = ($urandom_range(7) == 0);
            jogada_feita     = ($urandom_range(3) == 0);
            fim_timer        = ($urandom_range(15) == 0);
            igual            = ($urandom_range(5) != 0);
            fim_sequencia    = ($urandom_range(2) == 0);
            ultima_sequencia = ($urandom_range(3) == 0);
            fimE             = 1'($urandom_range(1));
            tick("random", 0, 4'h0);
        end
    endtask

    initial begin
        for (int s = 0; s < 16; s++) out_tab[s] = 12'h000;
        out_tab[1]  = 12'b1010_1010_0000;
        out_tab[2]  = 12'b1000_0010_0000;
        out_tab[3]  = 12'b0000_0001_0000;
        out_tab[4]  = 12'b0000_0100_0000;
        out_tab[6]  = 12'b0100_0010_0000;
        out_tab[7]  = 12'b0001_0000_0000;
        out_tab[8]  = 12'b0000_0000_1100;
        out_tab[9]  = 12'b0000_0000_1010;
        out_tab[10] = 12'b0000_0000_1001;

        test_reset();
        test_start();
        test_round1();
        test_mid_error();
        test_timeout_tie();
        test_win();
        test_reset_mid();
        test_random();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Moore control unit that sequences the memory-game datapath (`fluxo_dados`): address and limit counters, play register, sync ROM comparison and the 3000-cycle play timeout. It runs rounds of growing length. Each round replays ROM addresses 0..limite against user plays. The game ends in win, error or timeout. It sits between the top level (`iniciar`, end-state flags, debug display) and the datapath control/status pins.

## Interface
Parameters: none. State encoding is fixed; see Operation.

Ports:
- `clock` in 1 — single system clock; all state changes on the rising edge.
- `reset` in 1 — synchronous, active-low; 0 at a rising edge forces `inicial`.
- `iniciar` in 1 — start/restart request, level-sampled.
- `igual` in 1 — ROM data equals registered play.
- `fim_sequencia` in 1 — address counter equals limit counter.
- `ultima_sequencia` in 1 — limit counter at 15 (rco).
- `jogada_feita` in 1 — one-cycle play pulse from the edge detector.
- `fim_timer` in 1 — timeout counter terminal count (3000 cycles).
- `fimE` in 1 — address counter rco; debug only, no effect on transitions.
- `zeraE`, `contaE` out 1 — clear / increment the address counter.
- `zeraL`, `contaL` out 1 — clear / increment the limit counter.
- `zeraR`, `registraR` out 1 — clear / load the play register.
- `zera_timer`, `conta_timer` out 1 — clear / enable the timeout counter.
- `pronto` out 1 — game finished; high in all three end states.
- `acertou`, `errou`, `timeout` out 1 — end-state result flags (one-hot).
- `db_estado` out 4 — current state code, for the hex display.

## Operation
States are listed as code, name, asserted outputs, then next state:
- 0 `inicial`: no outputs asserted. Goes to 1 if `iniciar`=1, else stays.
- 1 `preparacao`: `zeraE`, `zeraL`, `zeraR`, `zera_timer`. Goes to 2 unconditionally.
- 2 `inicio_rodada`: `zeraE`, `zera_timer`. Goes to 3.
- 3 `espera_jogada`: `conta_timer`.
  - Goes to 4 if `jogada_feita`=1.
  - Otherwise goes to A if `fim_timer`=1.
  - Otherwise stays.
- 4 `registra`: `registraR`. Goes to 5.
- 5 `comparacao`: no outputs asserted. Priority order:
  - `igual`=0 → 9.
  - `fim_sequencia`=1 and `ultima_sequencia`=1 → 8.
  - `fim_sequencia`=1 → 7.
  - Otherwise → 6.
- 6 `proximo_endereco`: `contaE`, `zera_timer`. Goes to 3.
- 7 `proxima_rodada`: `contaL`. Goes to 2.
- 8 `fim_acertou`: `pronto`, `acertou`. Goes to 1 if `iniciar`=1, else stays.
- 9 `fim_errou`: `pronto`, `errou`. Same exit as 8.
- A `fim_timeout`: `pronto`, `timeout`. Same exit as 8.
- Codes B–F are illegal and go to 0 at the next edge; outputs are all 0 while in them.

Output and priority rules:
- All outputs decode from the state register only (pure Moore).
- `iniciar` is ignored outside states 0, 8, 9 and A.
- `reset`=0 has priority over every transition.
- The timer is cleared at round start and after each correct play, so each play gets its own 3000-cycle window.
- `fimE` has no effect on transitions; the round end is taken from `fim_sequencia`.

## Timing
- Reset: at the first rising edge with `reset`=0, the state becomes 0. From then on all outputs are 0 and `db_estado`=0. This holds while `reset` stays 0. Reset in any state, including mid-round, aborts to 0 and needs a new `iniciar`.
- Start latency: `iniciar` sampled high at edge k gives state 1 during k..k+1, state 2 next, and state 3 at edge k+2.
- Play path, with `jogada_feita` high in state 3 at edge t:
  - `registraR` is high for the cycle t..t+1, so the register captures at edge t+1.
  - `comparacao` evaluates `igual` in cycle t+1..t+2, using the registered play and the ROM word already stable for the current address.
  - The next state is taken at edge t+2.
- Simultaneous `jogada_feita` and `fim_timer` in state 3: the play wins and the next state is 4.
- Timeout: from entry into state 3, `fim_timer` asserts when the counter reaches 2999; the next state is A.
- Control pulses (`contaE`, `contaL`, `registraR`) last exactly one cycle per state visit.
- `iniciar` held high: the state leaves 0 or an end state on the first edge it is seen. Holding it longer has no further effect until the next end state; if it is still high then, the game restarts immediately.

## Test plan
- Reset mid-game: drive `reset`=0 for 2 edges while in state 3 → `db_estado`=0 and all outputs 0 on the first edge; the state stays 0 after release until `iniciar`.
- Start: pulse `iniciar` for 1 cycle → `db_estado` goes 0,1,2,3. In state 1, `zeraE`, `zeraL`, `zeraR` and `zera_timer` are all 1.
- Round 1 correct: in state 3 pulse `jogada_feita`, with `igual`=1, `fim_sequencia`=1, `ultima_sequencia`=0 → states 4,5,7,2,3, with `contaL` high for exactly 1 cycle.
- Mid-round correct then error:
  - With `fim_sequencia`=0 and `igual`=1 → 5,6,3, with `contaE` and `zera_timer` high for 1 cycle.
  - On the next play with `igual`=0 → state 9 with `pronto`=1 and `errou`=1, held until `iniciar`, then state 1.
- Timeout and tie:
  - No play while `fim_timer` rises in state 3 → state A with `timeout`=1.
  - Repeat with `jogada_feita` and `fim_timer` high in the same cycle → state 4.
- Win: `igual`=1, `fim_sequencia`=1, `ultima_sequencia`=1 at state 5 → state 8 with `acertou`=1, `pronto`=1. Force illegal code C → state 0 on the next edge.
